// File: rtl/fetch_stage.sv
// Instruction-fetch stage: fetch PC, single-outstanding imem port,
// skid register for stalled responses and the IF/ID pipeline register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_IF,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_ID,
  output logic [31:0] PC_plus4_ID,
  output logic [31:0] Instr_ID,
  output logic        valid_ID,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } skid_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        discard_q, discard_d;
  skid_t       skid_q, skid_d;
  if_id_t      ifid_q, ifid_d;
  logic [31:0] count_q, count_d;

  logic [31:0] redir_pc;
  logic [31:0] pc_inc;

  assign redir_pc = redirect_pc & 32'hFFFF_FFFC;
  assign pc_inc   = fetch_pc_q + 32'd4;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_REQ;
      fetch_pc_q <= RESET_PC;
      discard_q  <= 1'b0;
      skid_q     <= '0;
      ifid_q     <= '{pc: 32'd0, instr: NOP_INSTR, valid: 1'b0};
      count_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      discard_q  <= discard_d;
      skid_q     <= skid_d;
      ifid_q     <= ifid_d;
      count_q    <= count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    discard_d  = discard_q;
    skid_d     = skid_q;
    ifid_d     = ifid_q;
    count_d    = count_q;

    // Unstalled with nothing new to hand over: decode sees a bubble
    if (!stall_IF) begin
      ifid_d = '{pc: ifid_q.pc, instr: NOP_INSTR, valid: 1'b0};
    end

    unique case (state_q)
      S_REQ: begin
        if (imem_gnt) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (discard_q) begin
            discard_d = 1'b0;
            state_d   = S_REQ;
          end else if (!stall_IF) begin
            ifid_d     = '{pc: fetch_pc_q,
                           instr: imem_rdata,
                           valid: 1'b1};
            fetch_pc_d = pc_inc;
            count_d    = count_q + 32'd1;
            state_d    = S_REQ;
          end else begin
            skid_d  = '{pc: fetch_pc_q,
                        instr: imem_rdata};
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!stall_IF) begin
          ifid_d     = '{pc: skid_q.pc,
                         instr: skid_q.instr,
                         valid: 1'b1};
          fetch_pc_d = pc_inc;
          count_d    = count_q + 32'd1;
          state_d    = S_REQ;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase

    // Redirect overrides everything above, including a stall
    if (redirect_valid) begin
      ifid_d     = '{pc: ifid_q.pc, instr: NOP_INSTR, valid: 1'b0};
      fetch_pc_d = redir_pc;
      count_d    = count_q;
      unique case (state_q)
        S_REQ: begin
          if (imem_gnt) begin
            state_d   = S_WAIT;
            discard_d = 1'b1;
          end else begin
            state_d   = S_REQ;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            state_d   = S_REQ;
            discard_d = 1'b0;
          end else begin
            state_d   = S_WAIT;
            discard_d = 1'b1;
          end
        end
        default: begin
          state_d = S_REQ;
        end
      endcase
    end
  end

  assign imem_req    = reset && (state_q == S_REQ);
  assign imem_addr   = fetch_pc_q;
  assign PC_ID       = ifid_q.pc;
  assign PC_plus4_ID = ifid_q.pc + 32'd4;
  assign Instr_ID    = ifid_q.instr;
  assign valid_ID    = ifid_q.valid;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: scoreboard of expected IF/ID loads
// checked by a monitor, plus direct checks of port and IF/ID state.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_IF;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] PC_ID;
  logic [31:0] PC_plus4_ID;
  logic [31:0] Instr_ID;
  logic        valid_ID;
  logic [31:0] fetch_count;

  fetch_stage dut (
    .clk(clk),
    .reset(reset),
    .stall_IF(stall_IF),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .PC_ID(PC_ID),
    .PC_plus4_ID(PC_plus4_ID),
    .Instr_ID(Instr_ID),
    .valid_ID(valid_ID),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc_n  = 0;

  always @(posedge clk) cyc_n++;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] cnt;
    int          gap;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc,
                      input logic [31:0] instr,
                      input logic [31:0] cnt,
                      input int gap);
    exp_t e;
    e.pc    = pc;
    e.instr = instr;
    e.cnt   = cnt;
    e.gap   = gap;
    sb.push_back(e);
  endtask

  task automatic step(input logic gnt,
                      input logic rv,
                      input logic [31:0] rd,
                      input logic st,
                      input logic rdr,
                      input logic [31:0] rpc);
    imem_gnt       = gnt;
    imem_rvalid    = rv;
    imem_rdata     = rd;
    stall_IF       = st;
    redirect_valid = rdr;
    redirect_pc    = rpc;
    @(posedge clk);
    @(negedge clk);
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    redirect_valid = 1'b0;
  endtask

  // Monitor: a change of fetch_count with valid_ID marks a new load
  logic [31:0] mon_last_cnt = 32'd0;
  int          mon_last_cyc = 0;
  exp_t        mon_e;

  initial begin
    forever begin
      @(negedge clk);
      if (reset && valid_ID && fetch_count !== mon_last_cnt) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_load: got pc %h cnt %h expected none",
                   PC_ID, fetch_count);
        end else begin
          mon_e = sb.pop_front();
          chk("load_pc", PC_ID, mon_e.pc);
          chk("load_pc4", PC_plus4_ID, mon_e.pc + 32'd4);
          chk("load_instr", Instr_ID, mon_e.instr);
          chk("load_cnt", fetch_count, mon_e.cnt);
          if (mon_e.gap > 0) begin
            chk("load_gap", 32'(cyc_n - mon_last_cyc), 32'(mon_e.gap));
          end
        end
        mon_last_cyc = cyc_n;
      end
      mon_last_cnt = fetch_count;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b0;
    stall_IF       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'd0;

    @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_pc", PC_ID, 32'd0);
    chk("rst_pc4", PC_plus4_ID, 32'd4);
    chk("rst_instr", Instr_ID, 32'd0);
    chk("rst_valid", 32'(valid_ID), 32'd0);
    chk("rst_cnt", fetch_count, 32'd0);
    reset = 1'b1;
    #1;
    chk("t1_req", 32'(imem_req), 32'd1);
    chk("t1_addr", imem_addr, 32'h0);
    @(negedge clk);

    // 1: back-to-back fetches from a 1-cycle memory
    step(1, 0, 0, 0, 0, 0);
    chk("t1_wait_req", 32'(imem_req), 32'd0);
    push(32'h0, 32'h2001_0005, 32'd1, 0);
    step(0, 1, 32'h2001_0005, 0, 0, 0);
    chk("t1_addr4", imem_addr, 32'h4);
    step(1, 0, 0, 0, 0, 0);
    push(32'h4, 32'h2002_0043, 32'd2, 2);
    step(0, 1, 32'h2002_0043, 0, 0, 0);
    chk("t1_valid", 32'(valid_ID), 32'd1);

    // 2: stall across the response, skid hold, then release
    step(1, 0, 0, 1, 0, 0);
    chk("t2_hold_pc0", PC_ID, 32'h4);
    step(0, 1, 32'h8C03_0008, 1, 0, 0);
    for (int i = 0; i < 2; i++) begin
      chk("t2_hold_req", 32'(imem_req), 32'd0);
      chk("t2_hold_pc", PC_ID, 32'h4);
      chk("t2_hold_instr", Instr_ID, 32'h2002_0043);
      chk("t2_hold_valid", 32'(valid_ID), 32'd1);
      step(0, 0, 0, 1, 0, 0);
    end
    chk("t2_hold_req3", 32'(imem_req), 32'd0);
    chk("t2_hold_cnt", fetch_count, 32'd2);
    push(32'h8, 32'h8C03_0008, 32'd3, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("t2_req", 32'(imem_req), 32'd1);
    chk("t2_addr", imem_addr, 32'hC);

    // 3: redirect while waiting, late response dropped
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h40);
    chk("t3_valid", 32'(valid_ID), 32'd0);
    chk("t3_instr", Instr_ID, 32'h0);
    chk("t3_addr", imem_addr, 32'h40);
    chk("t3_req", 32'(imem_req), 32'd0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 32'hDEAD_BEEF, 0, 0, 0);
    chk("t3_cnt", fetch_count, 32'd3);
    chk("t3_req2", 32'(imem_req), 32'd1);
    chk("t3_addr2", imem_addr, 32'h40);
    chk("t3_valid2", 32'(valid_ID), 32'd0);
    step(1, 0, 0, 0, 0, 0);
    push(32'h40, 32'h3C01_0001, 32'd4, 0);
    step(0, 1, 32'h3C01_0001, 0, 0, 0);

    // 4: redirect coincident with grant, unaligned target
    step(1, 0, 0, 0, 1, 32'h103);
    chk("t4_req", 32'(imem_req), 32'd0);
    chk("t4_addr", imem_addr, 32'h100);
    step(0, 1, 32'hBAD0_0044, 0, 0, 0);
    chk("t4_cnt", fetch_count, 32'd4);
    chk("t4_req2", 32'(imem_req), 32'd1);
    chk("t4_addr2", imem_addr, 32'h100);
    step(1, 0, 0, 0, 0, 0);
    push(32'h100, 32'h0022_1820, 32'd5, 0);
    step(0, 1, 32'h0022_1820, 0, 0, 0);

    // 5: redirect while holding a skid under stall
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 32'hAAAA_0001, 1, 0, 0);
    chk("t5_hold_req", 32'(imem_req), 32'd0);
    step(0, 0, 0, 1, 1, 32'h200);
    chk("t5_valid", 32'(valid_ID), 32'd0);
    chk("t5_instr", Instr_ID, 32'h0);
    chk("t5_req", 32'(imem_req), 32'd1);
    chk("t5_addr", imem_addr, 32'h200);
    chk("t5_cnt", fetch_count, 32'd5);
    step(1, 0, 0, 0, 0, 0);
    push(32'h200, 32'h2442_0001, 32'd6, 0);
    step(0, 1, 32'h2442_0001, 0, 0, 0);

    // 6: async reset mid-wait, stale response after release
    step(1, 0, 0, 0, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_req", 32'(imem_req), 32'd0);
    chk("t6_pc", PC_ID, 32'd0);
    chk("t6_pc4", PC_plus4_ID, 32'd4);
    chk("t6_instr", Instr_ID, 32'd0);
    chk("t6_valid", 32'(valid_ID), 32'd0);
    chk("t6_cnt", fetch_count, 32'd0);
    chk("t6_addr", imem_addr, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    step(0, 1, 32'h5555_AAAA, 0, 0, 0);
    chk("t6_stale_cnt", fetch_count, 32'd0);
    chk("t6_stale_req", 32'(imem_req), 32'd1);
    chk("t6_stale_addr", imem_addr, 32'h0);
    step(1, 0, 0, 0, 0, 0);
    push(32'h0, 32'h2003_0007, 32'd1, 0);
    step(0, 1, 32'h2003_0007, 0, 0, 0);

    // Address wrap at the top of memory
    step(0, 0, 0, 0, 1, 32'hFFFF_FFFF);
    chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
    chk("wr_req", 32'(imem_req), 32'd1);
    step(1, 0, 0, 0, 0, 0);
    push(32'hFFFF_FFFC, 32'h0800_0000, 32'd2, 0);
    step(0, 1, 32'h0800_0000, 0, 0, 0);
    chk("wr_addr0", imem_addr, 32'h0);

    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
